// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: prioritised stall vector, registered flush/redirect.
// Optional perf counters (stall_cycles, flush_count) enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;
  logic        flush_nxt;
  logic [31:0] new_pc_nxt;
  logic        accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      flush     <= 1'b0;
      new_pc    <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      flush     <= flush_nxt;
      new_pc    <= new_pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    flush_nxt     = flush;
    new_pc_nxt    = new_pc;
    accept        = 1'b0;
    stall         = '0;
    case (state)
      RUN: begin
        // An exception wins over every stall request in the cycle it is taken.
        if (excp_valid) begin
          accept        = 1'b1;
          state_nxt     = FLUSH;
          flush_nxt     = 1'b1;
          new_pc_nxt    = excp_pc;
          flush_cnt_nxt = FLUSH_CNT_INIT;
        end else if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_nxt  = RUN;
          flush_nxt  = 1'b0;
          new_pc_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    if (!rst) begin
      stall  = '0;
      accept = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((stall != '0) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (accept && (flush_count != '1)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (FLUSH_CYCLES=1 and 3) share one stimulus stream.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid;
  logic [31:0] excp_pc;

  logic [5:0]  stall1, stall3;
  logic        flush1, flush3;
  logic [31:0] new_pc1, new_pc3;
  logic [31:0] stall_cycles1, stall_cycles3;
  logic [15:0] flush_count1, flush_count3;

  int unsigned n_checks;
  int unsigned n_fail;

  pipe_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_pc(excp_pc),
    .stall(stall1), .flush(flush1), .new_pc(new_pc1),
    .stall_cycles(stall_cycles1), .flush_count(flush_count1)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_pc(excp_pc),
    .stall(stall3), .flush(flush3), .new_pc(new_pc3),
    .stall_cycles(stall_cycles3), .flush_count(flush_count3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excp_valid   = 1'b0;
    excp_pc      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    stallreq_mem = 1'b1;
    stallreq_if  = 1'b1;
    excp_valid   = 1'b1;
    excp_pc      = 32'hDEAD_BEEF;
    step();
    step();
    n_checks++;
    if (stall1 !== 6'b000000 || stall3 !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_stall: got %b/%b expected 000000", stall1, stall3);
    end
    n_checks++;
    if (flush1 !== 1'b0 || flush3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flush: got %b/%b expected 0", flush1, flush3);
    end
    n_checks++;
    if (new_pc1 !== 32'h0 || new_pc3 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_new_pc: got %h/%h expected 0", new_pc1, new_pc3);
    end
    n_checks++;
    if (stall_cycles1 !== 32'h0 || flush_count1 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles1, flush_count1);
    end
    clear_inputs();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_stall_priority();
    // {mem, ex, id, if} -> expected stall vector
    logic [3:0] reqs [7];
    logic [5:0] exp_stall [7];
    reqs[0] = 4'b1010; exp_stall[0] = 6'b011111;
    reqs[1] = 4'b0010; exp_stall[1] = 6'b000111;
    reqs[2] = 4'b0110; exp_stall[2] = 6'b001111;
    reqs[3] = 4'b0011; exp_stall[3] = 6'b000111;
    reqs[4] = 4'b0001; exp_stall[4] = 6'b000011;
    reqs[5] = 4'b0000; exp_stall[5] = 6'b000000;
    reqs[6] = 4'b1111; exp_stall[6] = 6'b011111;
    for (int i = 0; i < 7; i++) begin
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = reqs[i];
      #1;
      n_checks++;
      if (stall1 !== exp_stall[i] || stall3 !== exp_stall[i]) begin
        n_fail++;
        $display("FAIL stall_prio[%0d] reqs=%b: got %b/%b expected %b",
                 i, reqs[i], stall1, stall3, exp_stall[i]);
      end
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_excp_over_stall();
    do_reset();
    stallreq_ex = 1'b1;
    excp_valid  = 1'b1;
    excp_pc     = 32'h0000_0020;
    #1;
    n_checks++;
    if (stall1 !== 6'b000000 || stall3 !== 6'b000000) begin
      n_fail++;
      $display("FAIL excp_stall_override: got %b/%b expected 000000", stall1, stall3);
    end
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (flush1 !== 1'b1 || new_pc1 !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL excp_flush1_first: flush=%b new_pc=%h expected 1/00000020", flush1, new_pc1);
    end
    step();
    n_checks++;
    if (flush1 !== 1'b0 || new_pc1 !== 32'h0) begin
      n_fail++;
      $display("FAIL excp_flush1_end: flush=%b new_pc=%h expected 0/00000000", flush1, new_pc1);
    end
    n_checks++;
    if (flush3 !== 1'b1 || new_pc3 !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL excp_flush3_mid: flush=%b new_pc=%h expected 1/00000020", flush3, new_pc3);
    end
    step();
    step();
    n_checks++;
    if (flush3 !== 1'b0 || new_pc3 !== 32'h0) begin
      n_fail++;
      $display("FAIL excp_flush3_end: flush=%b new_pc=%h expected 0/00000000", flush3, new_pc3);
    end
  endtask

  task automatic test_flush3();
    do_reset();
    excp_valid = 1'b1;
    excp_pc    = 32'h0000_0040;
    step();
    excp_valid   = 1'b0;
    stallreq_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // Requests during flush must be ignored, including a fresh exception.
      excp_valid = (i == 1);
      excp_pc    = (i == 1) ? 32'h0000_0999 : 32'h0000_0040;
      #1;
      n_checks++;
      if (flush3 !== 1'b1 || new_pc3 !== 32'h0000_0040 || stall3 !== 6'b000000) begin
        n_fail++;
        $display("FAIL flush3_cycle%0d: flush=%b new_pc=%h stall=%b expected 1/00000040/000000",
                 i, flush3, new_pc3, stall3);
      end
      step();
    end
    excp_valid = 1'b0;
    #1;
    n_checks++;
    if (flush3 !== 1'b0 || stall3 !== 6'b011111) begin
      n_fail++;
      $display("FAIL flush3_after: flush=%b stall=%b expected 0/011111", flush3, stall3);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    excp_valid = 1'b1;
    excp_pc    = 32'h0000_0100;
    step();
    excp_valid = 1'b0;
    step();
    excp_valid = 1'b1;
    excp_pc    = 32'h0000_0180;
    #1;
    n_checks++;
    if (flush1 !== 1'b0 || stall1 !== 6'b000000) begin
      n_fail++;
      $display("FAIL b2b_run_cycle: flush=%b stall=%b expected 0/000000", flush1, stall1);
    end
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (flush1 !== 1'b1 || new_pc1 !== 32'h0000_0180) begin
      n_fail++;
      $display("FAIL b2b_second_flush: flush=%b new_pc=%h expected 1/00000180", flush1, new_pc1);
    end
    step();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    excp_valid = 1'b1;
    excp_pc    = 32'h0000_0044;
    step();
    excp_valid = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (flush3 !== 1'b0 || new_pc3 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_flush: flush=%b new_pc=%h expected 0/00000000", flush3, new_pc3);
    end
    step();
    rst = 1'b1;
    #1;
    stallreq_mem = 1'b1;
    #1;
    n_checks++;
    if (flush3 !== 1'b0 || stall3 !== 6'b011111) begin
      n_fail++;
      $display("FAIL rst_mid_flush_run: flush=%b stall=%b expected 0/011111", flush3, stall3);
    end
    clear_inputs();
  endtask

  task automatic test_counters();
    logic [31:0] exp_sc;
    logic [15:0] exp_fc;
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_sc = 32'd5;
    exp_fc = 16'd2;
`else
    exp_sc = 32'd0;
    exp_fc = 16'd0;
`endif
    do_reset();
    stallreq_if = 1'b1;
    repeat (5) step();
    stallreq_if = 1'b0;
    for (int k = 0; k < 2; k++) begin
      excp_valid = 1'b1;
      excp_pc    = 32'h0000_1000;
      step();
      excp_valid = 1'b0;
      repeat (4) step();
    end
    n_checks++;
    if (stall_cycles1 !== exp_sc || stall_cycles3 !== exp_sc) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d/%0d expected %0d", stall_cycles1, stall_cycles3, exp_sc);
    end
    n_checks++;
    if (flush_count1 !== exp_fc || flush_count3 !== exp_fc) begin
      n_fail++;
      $display("FAIL flush_count: got %0d/%0d expected %0d", flush_count1, flush_count3, exp_fc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst = 1'b1;
    #2;
    test_reset();
    test_stall_priority();
    test_excp_over_stall();
    test_flush3();
    test_back_to_back();
    test_reset_mid_flush();
    test_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, number of cycles flush is held after an accepted exception (legal 1..7).
REQ-002 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Port stallreq_if  input  1  fetch bus wait.
REQ-005 Port stallreq_id  input  1  decode load-use hazard.
REQ-006 Port stallreq_ex  input  1  multi-cycle execute (div/madd) busy.
REQ-007 Port stallreq_mem  input  1  data bus wait.
REQ-008 Port excp_valid  input  1  exception or eret detected at mem stage.
REQ-009 Port excp_pc  input  32  redirect target (Reg_t) for excp_valid.
REQ-010 Port stall  output  6  stall vector: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
REQ-011 Port flush  output  1  clears all pipeline registers.
REQ-012 Port new_pc  output  32  redirect target, valid while flush=1.
REQ-013 Port stall_cycles  output  32  count of cycles with stall!=0.
REQ-014 Port flush_count  output  16  count of accepted exceptions.

Function
REQ-015 States RUN and FLUSH; flush, new_pc, state, counters registered; stall combinational from inputs and state.
REQ-016 In RUN, stall priority: stallreq_mem -> 011111; else stallreq_ex -> 001111; else stallreq_id -> 000111; else stallreq_if -> 000011; else 000000.
REQ-017 In RUN, excp_valid=1 accepted regardless of stall requests: next edge state=FLUSH, flush=1, new_pc=excp_pc, flush_cnt loaded FLUSH_CYCLES-1.
REQ-018 In the cycle excp_valid is accepted, stall=000000 (exception overrides stalls).
REQ-019 In FLUSH, stall=000000 and all stallreq_* and excp_valid ignored.
REQ-020 In FLUSH, flush_cnt decrements each edge; at flush_cnt=0 next edge state=RUN, flush=0, new_pc=0.
REQ-021 Latency: excp_valid at edge N -> flush=1 cycles N+1..N+FLUSH_CYCLES, RUN at N+FLUSH_CYCLES+1.
REQ-022 new_pc holds constant for the whole FLUSH interval.
REQ-023 Back-to-back excp_valid asserted in the first RUN cycle after FLUSH is accepted normally.
REQ-024 stall_cycles increments each edge where stall!=0; saturates at FFFFFFFF.
REQ-025 flush_count increments on each accepted exception; saturates at FFFF.

Reset
REQ-026 rst=0 asynchronously forces state=RUN, flush=0, new_pc=0, flush_cnt=0, stall_cycles=0, flush_count=0.
REQ-027 While rst=0, stall=000000 regardless of inputs.
REQ-028 Reset asserted mid-FLUSH aborts the flush immediately; after release block starts in RUN.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_CNT_EN defined: stall_cycles and flush_count implemented per REQ-024/025.
REQ-030 Macro undefined: no counter registers; stall_cycles and flush_count tied to 0; all other behaviour identical.

Verification
REQ-031 stallreq_mem=1 and stallreq_id=1 together in RUN -> stall=011111 same cycle; drop mem -> 000111.
REQ-032 excp_valid=1, excp_pc=0x00000020 while stallreq_ex=1, FLUSH_CYCLES=1 -> stall=000000 that cycle, next cycle flush=1 new_pc=0x00000020, then flush=0 RUN.
REQ-033 FLUSH_CYCLES=3, excp_valid pulse plus stallreq_mem=1 during flush -> flush=1 exactly 3 cycles, stall=000000 throughout, then stall=011111.
REQ-034 rst=0 asserted in second FLUSH cycle -> flush=0 and new_pc=0 without clock edge; after release, RUN.
REQ-035 With PIPE_CTRL_PERF_CNT_EN: 5 stalled cycles then 2 exceptions -> stall_cycles=5, flush_count=2; without macro both read 0.
